// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode between fetch and execute.
// Decodes {fn, op}, holds the bundle behind a valid/ready handshake, tracks
// outstanding register writes to stall on RAW/WAW hazards, and counts stalls.
// Legal encodings beyond the fixed ALU codes:
//   compare (fn 1101/0101) and branch (fn 0010): op 0000..0101 -> alu_op 10..15
//   load, store, JAL: op 0000 only, alu_op 1 (address add)
module decode_stage #(
   parameter int INST_BIT_WIDTH      = 32,
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int IMM_BIT_WIDTH       = 32,
   parameter int PC_BIT_WIDTH        = 32,
   parameter int STALL_CNT_WIDTH     = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic [INST_BIT_WIDTH-1:0]      in_inst,
   input  logic [PC_BIT_WIDTH-1:0]        in_pc,
   output logic                           in_ready,
   output logic                           out_valid,
   input  logic                           out_ready,
   input  logic                           flush,
   input  logic                           wb_valid,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_index,
   output logic [PC_BIT_WIDTH-1:0]        out_pc,
   output logic [REG_INDEX_BIT_WIDTH-1:0] out_src1,
   output logic [REG_INDEX_BIT_WIDTH-1:0] out_src2,
   output logic [REG_INDEX_BIT_WIDTH-1:0] out_dst,
   output logic [IMM_BIT_WIDTH-1:0]       out_imm,
   output logic [4:0]                     out_alu_op,
   output logic                           out_alu_src_imm,
   output logic                           out_mem_to_reg,
   output logic                           out_reg_wr_en,
   output logic                           out_mem_wr_en,
   output logic                           out_is_branch,
   output logic                           out_is_jal,
   output logic                           out_illegal,
   output logic [STALL_CNT_WIDTH-1:0]     stall_count
);

   localparam int RW       = REG_INDEX_BIT_WIDTH;
   localparam int NUM_REGS = 2 ** REG_INDEX_BIT_WIDTH;

   logic [3:0]               fn, op;
   logic [RW-1:0]            field_a, field_b, field_c;
   logic [IMM_BIT_WIDTH-1:0] imm_plain, imm_jal;

   assign fn        = in_inst[31:28];
   assign op        = in_inst[27:24];
   assign field_a   = RW'(in_inst[23:20]);
   assign field_b   = RW'(in_inst[19:16]);
   assign field_c   = RW'(in_inst[15:12]);
   assign imm_plain = {{(IMM_BIT_WIDTH-16){in_inst[15]}}, in_inst[15:0]};
   assign imm_jal   = {{(IMM_BIT_WIDTH-18){in_inst[15]}}, in_inst[15:0], 2'b00};

   logic [4:0]               r_code;
   logic [RW-1:0]            dec_src1, dec_src2, dec_dst;
   logic [IMM_BIT_WIDTH-1:0] dec_imm;
   logic [4:0]               dec_alu_op;
   logic                     dec_src_imm, dec_m2r, dec_rwe, dec_mwe, dec_br, dec_jal, dec_ill;
   logic                     use_src1, use_src2;

   // Register-form ALU op code; 0 marks an op that is not on the sheet.
   always_comb begin
      case (op)
         4'b0111: r_code = 5'd1;
         4'b0110: r_code = 5'd2;
         4'b0000: r_code = 5'd3;
         4'b0001: r_code = 5'd4;
         4'b0010: r_code = 5'd5;
         4'b1000: r_code = 5'd6;
         4'b1001: r_code = 5'd7;
         4'b1010: r_code = 5'd8;
         default: r_code = 5'd0;
      endcase
   end

   // Decode table: fields, control bits, used sources and legality.
   always_comb begin
      dec_src1    = field_b;
      dec_src2    = field_c;
      dec_dst     = field_a;
      dec_imm     = imm_plain;
      dec_alu_op  = 5'd0;
      dec_src_imm = 1'b0;
      dec_m2r     = 1'b0;
      dec_rwe     = 1'b0;
      dec_mwe     = 1'b0;
      dec_br      = 1'b0;
      dec_jal     = 1'b0;
      dec_ill     = 1'b0;
      use_src1    = 1'b0;
      use_src2    = 1'b0;
      case (fn)
         4'b1100: begin
            dec_alu_op = r_code;
            dec_ill    = (r_code == 5'd0);
            dec_rwe    = 1'b1;
            use_src1   = 1'b1;
            use_src2   = 1'b1;
         end
         4'b0100: begin
            dec_alu_op  = (op == 4'b1111) ? 5'd9 : r_code;
            dec_ill     = (op != 4'b1111) && (r_code == 5'd0);
            dec_src_imm = 1'b1;
            dec_rwe     = 1'b1;
            use_src1    = 1'b1;
         end
         4'b1101, 4'b0101: begin
            if (op < 4'd6) dec_alu_op = 5'd10 + {1'b0, op};
            else           dec_ill    = 1'b1;
            dec_src_imm = ~fn[3];
            dec_rwe     = 1'b1;
            use_src1    = 1'b1;
            use_src2    = fn[3];
         end
         4'b0111: begin
            dec_ill     = (op != 4'b0000);
            dec_alu_op  = 5'd1;
            dec_src_imm = 1'b1;
            dec_m2r     = 1'b1;
            dec_rwe     = 1'b1;
            use_src1    = 1'b1;
         end
         4'b0011: begin
            dec_src2    = field_a;
            dec_ill     = (op != 4'b0000);
            dec_alu_op  = 5'd1;
            dec_src_imm = 1'b1;
            dec_mwe     = 1'b1;
            use_src1    = 1'b1;
            use_src2    = 1'b1;
         end
         4'b0010: begin
            dec_src1 = field_a;
            dec_src2 = field_b;
            if (op < 4'd6) dec_alu_op = 5'd10 + {1'b0, op};
            else           dec_ill    = 1'b1;
            dec_br   = 1'b1;
            use_src1 = 1'b1;
            use_src2 = 1'b1;
         end
         4'b0110: begin
            dec_imm     = imm_jal;
            dec_ill     = (op != 4'b0000);
            dec_alu_op  = 5'd1;
            dec_src_imm = 1'b1;
            dec_m2r     = 1'b1;
            dec_rwe     = 1'b1;
            dec_jal     = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
      // Illegal words travel on to execute but must not write or redirect.
      if (dec_ill) begin
         dec_rwe  = 1'b0;
         dec_mwe  = 1'b0;
         dec_br   = 1'b0;
         dec_jal  = 1'b0;
         use_src1 = 1'b0;
         use_src2 = 1'b0;
      end
   end

   logic [NUM_REGS-1:0]        pending_reg, pending_next, busy, set_mask, clr_mask;
   logic [STALL_CNT_WIDTH-1:0] stall_count_reg, stall_count_next;
   logic                       hazard, accept, issue;

   // A bundle leaving execute-ward sets its bit; one killed by flush never left.
   assign issue = out_valid & out_ready & out_reg_wr_en & ~flush;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
         // Busy covers both retired-to-scoreboard writes and the bundle leaving now.
         assign busy[gi]     = pending_reg[gi] |
                               (out_valid & out_reg_wr_en & ~flush & (out_dst == RW'(gi)));
         assign set_mask[gi] = issue & (out_dst == RW'(gi));
         assign clr_mask[gi] = wb_valid & (wb_index == RW'(gi));
      end
   endgenerate

   assign hazard       = (use_src1 & busy[dec_src1]) | (use_src2 & busy[dec_src2]) |
                         (dec_rwe & busy[dec_dst]);
   assign in_ready     = ~hazard & (~out_valid | out_ready);
   assign accept       = in_valid & in_ready & ~flush;
   assign pending_next = (pending_reg & ~clr_mask) | set_mask;
   assign stall_count_next = (in_valid & hazard & ~flush & ~(&stall_count_reg)) ?
                             stall_count_reg + STALL_CNT_WIDTH'(1) : stall_count_reg;
   assign stall_count  = stall_count_reg;

   // Scoreboard and stall counter state.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_reg     <= '0;
         stall_count_reg <= '0;
      end else begin
         pending_reg     <= pending_next;
         stall_count_reg <= stall_count_next;
      end
   end

   // Output bundle register: flush beats accept, accept beats hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid       <= 1'b0;
         out_pc          <= '0;
         out_src1        <= '0;
         out_src2        <= '0;
         out_dst         <= '0;
         out_imm         <= '0;
         out_alu_op      <= '0;
         out_alu_src_imm <= 1'b0;
         out_mem_to_reg  <= 1'b0;
         out_reg_wr_en   <= 1'b0;
         out_mem_wr_en   <= 1'b0;
         out_is_branch   <= 1'b0;
         out_is_jal      <= 1'b0;
         out_illegal     <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid       <= 1'b1;
         out_pc          <= in_pc;
         out_src1        <= dec_src1;
         out_src2        <= dec_src2;
         out_dst         <= dec_dst;
         out_imm         <= dec_imm;
         out_alu_op      <= dec_alu_op;
         out_alu_src_imm <= dec_src_imm;
         out_mem_to_reg  <= dec_m2r;
         out_reg_wr_en   <= dec_rwe;
         out_mem_wr_en   <= dec_mwe;
         out_is_branch   <= dec_br;
         out_is_jal      <= dec_jal;
         out_illegal     <= dec_ill;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
